bcd_conv_arbiter: RTL and testbench

//  Shares one iterative BCD->binary conversion datapath between NREQ requesters (keypad/IO/display paths).

---
 rtl/bcd_conv_pkg.sv | 6 +
 rtl/bcd_conv_arbiter_if.sv | 26 ++
 rtl/bcd_rr_arbiter.sv | 32 +++
 rtl/bcd_conv_arbiter.sv | 113 +++++++++++
 tb/tb_bcd_conv_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the BCD-to-binary conversion arbiter.
package bcd_conv_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;
endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester/consumer handshake bundle for bcd_conv_arbiter; slave is the converter side.
interface bcd_conv_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DIGITS = 4,
  parameter int BW     = 16
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*4*DIGITS-1:0] req_bcd;
  logic [NREQ-1:0]          req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [BW-1:0]            rsp_bin;
  logic [IW-1:0]            rsp_id;
  logic                     rsp_err;

  modport master (
    output req_valid, req_bcd, rsp_ready,
    input  req_ready, rsp_valid, rsp_bin, rsp_id, rsp_err
  );
  modport slave (
    input  req_valid, req_bcd, rsp_ready,
    output req_ready, rsp_valid, rsp_bin, rsp_id, rsp_err
  );
endinterface

// File: rtl/bcd_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module bcd_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shared digit-serial BCD->binary converter with round-robin requester arbitration.
// Optional digit range checking is enabled by defining BCDCONV_CHECK_EN.
module bcd_conv_arbiter
  import bcd_conv_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DIGITS = 4,
  parameter int BW     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_conv_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NREQ);
  localparam int WW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t               state;
  logic [IW-1:0]        rr_ptr, gnt_idx, own_id, rsp_id_q;
  logic [NREQ-1:0]      gnt;
  logic                 gnt_any;
  logic [WW-1:0]        word;
  logic [BW-1:0]        acc, bin_q;
  logic [CW-1:0]        cnt;
  logic                 vld_q;
  logic [DIGIT_W-1:0]   digit;

`ifdef BCDCONV_CHECK_EN
  logic err_acc, err_q;
`else
  logic err_q;
  assign err_q = 1'b0;
`endif

  bcd_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Gated by rst_n so the ready lines read zero while reset is held.
  assign bus.req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_bin   = bin_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = err_q;

  // Word shifts left each MAC step, so the current digit is always the top nibble.
  assign digit = word[WW-1 -: DIGIT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      own_id   <= '0;
      word     <= '0;
      acc      <= '0;
      cnt      <= '0;
      vld_q    <= 1'b0;
      bin_q    <= '0;
      rsp_id_q <= '0;
`ifdef BCDCONV_CHECK_EN
      err_acc  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            word    <= bus.req_bcd[int'(gnt_idx)*WW +: WW];
            own_id  <= gnt_idx;
            acc     <= '0;
            cnt     <= '0;
            rr_ptr  <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`ifdef BCDCONV_CHECK_EN
            err_acc <= 1'b0;
`endif
            state   <= CONV;
          end
        end
        CONV: begin
          if (cnt == CW'(DIGITS)) begin
            vld_q    <= 1'b1;
            rsp_id_q <= own_id;
`ifdef BCDCONV_CHECK_EN
            bin_q    <= err_acc ? '0 : acc;
            err_q    <= err_acc;
`else
            bin_q    <= acc;
`endif
            state    <= DONE;
          end else begin
            acc  <= (acc << 3) + (acc << 1) + BW'(digit);
            word <= word << DIGIT_W;
            cnt  <= cnt + 1'b1;
`ifdef BCDCONV_CHECK_EN
            err_acc <= err_acc | (digit > MAX_DIGIT);
`endif
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: vector table plus scoreboard-checked sequences.
module tb_bcd_conv_arbiter;
  localparam int NREQ   = 2;
  localparam int DIGITS = 4;
  localparam int BW     = 16;
  localparam int WW     = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.NREQ(NREQ), .DIGITS(DIGITS), .BW(BW)) bus();
  bcd_conv_arbiter #(.NREQ(NREQ), .DIGITS(DIGITS), .BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] bin;
    int            id;
    logic          err;
    int            acc_cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int            id;
    logic [WW-1:0] bcd;
    logic [BW-1:0] bin;
    logic          err;
  } vec_t;
  vec_t vt[7];

  int            acc_cnt = 0;
  int            rsp_cnt = 0;
  int            grant_log[16];
  logic [BW-1:0] last_bin = '0;
  int            last_id = 0;
  logic          last_err = 1'b0;
  logic          prev_vld = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference conversion: {err, bin}, MSD first.
  function automatic logic [BW:0] model(input logic [WW-1:0] w);
    logic [BW-1:0] a;
    logic          e;
    logic [3:0]    d;
    a = '0;
    e = 1'b0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      d = w[k*4 +: 4];
      if (d > 4'd9) e = 1'b1;
      a = BW'(a * 10 + d);
    end
`ifdef BCDCONV_CHECK_EN
    if (e) a = '0;
    return {e, a};
`else
    return {1'b0, a};
`endif
  endfunction

  // Accept observer and response scoreboard, sampled 1 time unit after the falling edge.
  initial begin
    exp_t          e;
    logic [BW:0]   m;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            m = model(bus.req_bcd[i*WW +: WW]);
            sbq.push_back('{m[BW-1:0], i, m[BW], cyc + 1});
            grant_log[acc_cnt % 16] = i;
            acc_cnt++;
          end
        end
        if (bus.rsp_valid && !prev_vld) begin
          chk("rsp_expected", (sbq.size() != 0), 1);
          if (sbq.size() != 0) chk("latency", cyc - sbq[0].acc_cyc, DIGITS + 1);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          chk("rsp_expected", (sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_bin", bus.rsp_bin, e.bin);
            chk("sb_id", bus.rsp_id, e.id);
            chk("sb_err", bus.rsp_err, e.err);
          end
          last_bin = bus.rsp_bin;
          last_id  = int'(bus.rsp_id);
          last_err = bus.rsp_err;
          rsp_cnt++;
        end
      end
      prev_vld = bus.rsp_valid;
    end
  end

  task automatic send(input int id, input logic [WW-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_bcd[id*WW +: WW] = w;
    bus.req_valid[id] = 1'b1;
    #2;
    while (!bus.req_ready[id] && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("accept_timeout", (n < 100), 1);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int base);
    int n;
    n = 0;
    while (rsp_cnt == base && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("rsp_timeout", (rsp_cnt != base), 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_bin"},   bus.rsp_bin, 0);
    chk({tag, "_rsp_id"},    bus.rsp_id, 0);
    chk({tag, "_rsp_err"},   bus.rsp_err, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n;
    vt[0] = '{0, 16'h1234, 16'd1234, 1'b0};
    vt[1] = '{1, 16'h9999, 16'd9999, 1'b0};
    vt[2] = '{1, 16'h0000, 16'd0,    1'b0};
    vt[3] = '{0, 16'h0001, 16'd1,    1'b0};
    vt[4] = '{1, 16'h9000, 16'd9000, 1'b0};
`ifdef BCDCONV_CHECK_EN
    vt[5] = '{0, 16'h12A4, 16'd0,    1'b1};
    vt[6] = '{1, 16'hFFFF, 16'd0,    1'b1};
`else
    vt[5] = '{0, 16'h12A4, 16'd1304, 1'b0};
    vt[6] = '{1, 16'hFFFF, 16'd16665, 1'b0};
`endif

    bus.rsp_ready = 1'b1;
    bus.req_bcd   = '0;
    bus.req_valid = '1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, one at a time.
    for (int i = 0; i < 7; i++) begin
      base = rsp_cnt;
      send(vt[i].id, vt[i].bcd);
      wait_rsp(base);
      chk("vec_bin", last_bin, vt[i].bin);
      chk("vec_id",  last_id,  vt[i].id);
      chk("vec_err", last_err, vt[i].err);
    end

    // Consumer stalls 10 cycles in DONE while another requester waits.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    send(0, 16'h4321);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("stall_rsp_timeout", bus.rsp_valid, 1);
    @(negedge clk);
    bus.req_bcd[1*WW +: WW] = 16'h0777;
    bus.req_valid[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #2;
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_bin",   bus.rsp_bin, 4321);
      chk("stall_id",    bus.rsp_id, 0);
      chk("stall_ready", bus.req_ready, 0);
    end
    base = rsp_cnt;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #2;
    chk("stall_pop", rsp_cnt, base + 1);
    chk("stall_pop_bin", last_bin, 4321);
    chk("bubble_ready", bus.req_ready, 0);
    @(negedge clk);
    #2;
    chk("idle_after_release", bus.req_ready, 2'b10);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    base = rsp_cnt;
    wait_rsp(base);
    chk("after_stall_bin", last_bin, 777);
    chk("after_stall_id",  last_id, 1);

    // Reset in the second conversion cycle; rr_ptr must return to 0.
    send(1, 16'h5555);
    @(posedge clk);
    #1;
    bus.req_bcd = {16'h0304, 16'h0102};
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    sbq.delete();
    base = acc_cnt;
    repeat (2) @(negedge clk);
    chk("midreset_no_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    #2;
    chk("post_reset_grant", bus.req_ready, 2'b01);

    // Both requesters held valid: grants must alternate.
    n = 0;
    while (acc_cnt < base + 4 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("rr_accept_timeout", (acc_cnt >= base + 4), 1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("rr_drain", sbq.size(), 0);
    chk("rr_grant0", grant_log[(base + 0) % 16], 0);
    chk("rr_grant1", grant_log[(base + 1) % 16], 1);
    chk("rr_grant2", grant_log[(base + 2) % 16], 0);
    chk("rr_grant3", grant_log[(base + 3) % 16], 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
